wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the pipelined core and the sole driver of the register-file write port. Accepts retiring instructions from the MEM stage, selects the result (ALU, PC+4 or load data), and waits for variable-latency load data. Performs byte/half extraction with sign/zero extension and drives a one-cycle write strobe into the register file. Also exports a bypass copy of the pending write, a load-pending indicator for the hazard unit, and the retired-instruction counter.

## Interface
- XLEN, 32, datapath width
- INSTRET_W, 64, retired-instruction counter width

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept; combinational, high exactly in IDLE
- in_rd_en  in  1  instruction writes rd
- in_rd_addr  in  5  destination register
- in_wb_sel  in  2  result source: 0 ALU, 1 MEM, 2 PC4; 3 reserved, treated as ALU
- in_alu_result  in  XLEN  ALU result
- in_pc  in  XLEN  instruction PC
- in_funct3  in  3  load width/sign code
- in_addr_lo  in  2  load address bits [1:0]
- mem_rvalid  in  1  load data valid, single-cycle pulse
- mem_rdata  in  XLEN  aligned load word
- flush  in  1  discard un-retired work
- rf_write_en, rf_write_addr (5), rf_write_value (XLEN)  out  register-file write port, registered
- fwd_valid, fwd_addr (5), fwd_value (XLEN)  out  bypass; mirror of the rf_write_* outputs
- load_pending  out  1  registered; high in WAIT_LOAD
- load_rd  out  5  rd of the pending load; 0 when none pending
- instret  out  INSTRET_W  retired-instruction count

## Operation
- States: IDLE, WAIT_LOAD.
- IDLE, accept (in_valid & in_ready & !flush):
  - wb_sel ALU/PC4: next-cycle rf_write_value = in_alu_result or in_pc+4 (mod 2^XLEN).
  - Write strobe: rf_write_en = in_rd_en & (in_rd_addr != 0). Stay in IDLE.
  - instret increments on every accept, including rd_en=0 and rd=x0.
- IDLE, MEM accept: latch rd_en, rd, funct3, addr_lo; go to WAIT_LOAD. No write that cycle. load_rd = rd when rd_en & rd≠0, else 0.
- WAIT_LOAD, mem_rvalid & !flush: write the extended data with the same x0 gating, increment instret, go to IDLE. Extension (sub-module):
  - 000 LB: byte at addr_lo, sign-extended.
  - 100 LBU: byte at addr_lo, zero-extended.
  - 001 LH: half at addr_lo[1], sign-extended.
  - 101 LHU: half at addr_lo[1], zero-extended.
  - 010 LW and all other codes: full word.
- flush has priority over in_valid and mem_rvalid.
  - In IDLE: nothing is accepted.
  - In WAIT_LOAD: return to IDLE with no write and no instret increment.
  - A write already registered still completes; flush does not clear rf_write_en.
- No write strobe for rd=x0 ever; rf_write_addr/value hold their last values when rf_write_en=0.
- instret wraps from 2^INSTRET_W−1 to 0.

## Timing
- Reset (asynchronous assert, synchronous release): IDLE; all rf_write_*, fwd_*, load_pending, load_rd and instret = 0; in_ready = 1.
- Non-load latency: accepted at edge N -> rf_write_en high for cycle N..N+1; register file commits at edge N+1. Throughput 1/cycle.
- Load: mem_rvalid sampled at edge M (any M ≥ acceptance edge + 1) -> rf_write_en high for the following cycle. mem_rvalid in IDLE is ignored.
- rf_write_en is high for exactly one cycle per write. It stays 0 in any cycle with no accept and no rvalid.
- fwd_* equals rf_write_* in the same cycle. This covers the window before the register file commits.
- Reset mid-load: pending load abandoned; a later mem_rvalid is ignored.

## Structure
- define.vh holds: WB_SEL_ALU/MEM/PC4 codes, LB/LH/LW/LBU/LHU funct3 codes, IDLE/WAIT_LOAD state encoding, XLEN default.
- One combinational sub-module, load_extend: inputs funct3, addr_lo, rdata; output extended XLEN value.

## Test plan
- ALU retire: accept rd=5, wb_sel=0, alu=0x1234_5678 -> next cycle rf_write_en=1, addr=5, value=0x1234_5678, fwd identical, instret=1.
- x0 and PC4: accept rd=0 ALU, then rd=1 PC4 pc=0xFFFF_FFFC on back-to-back cycles -> no strobe for the first, value 0x0000_0000 for the second, instret=2.
- Load extension: rdata=0x80FF_7F01, 3-cycle latency each:
  - LB addr_lo=3 -> 0xFFFF_FF80.
  - LBU addr_lo=1 -> 0x0000_007F.
  - LH addr_lo=2 -> 0xFFFF_80FF.
  - LHU addr_lo=0 -> 0x0000_7F01.
  - In every case in_ready=0 and load_pending=1 until rvalid.
- Flush vs rvalid: load rd=7, then flush and mem_rvalid in the same cycle -> no write, IDLE, instret unchanged, load_rd=0.
- Reset mid-load: deassert reset_n in WAIT_LOAD, release, pulse mem_rvalid -> no write, all outputs 0, in_ready=1.
- Wrap: preload instret to 2^64−1, retire one ALU op -> instret=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: result-select codes, load funct3 codes, FSM states.
package wb_stage_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } state_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of MEM-stage handshake, load-return, register-file write, bypass and status signals.
interface wb_stage_if #(
   parameter int XLEN      = 32,
   parameter int INSTRET_W = 64
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_rd_en;
   logic [4:0]           in_rd_addr;
   logic [1:0]           in_wb_sel;
   logic [XLEN-1:0]      in_alu_result;
   logic [XLEN-1:0]      in_pc;
   logic [2:0]           in_funct3;
   logic [1:0]           in_addr_lo;
   logic                 mem_rvalid;
   logic [XLEN-1:0]      mem_rdata;
   logic                 flush;
   logic                 rf_write_en;
   logic [4:0]           rf_write_addr;
   logic [XLEN-1:0]      rf_write_value;
   logic                 fwd_valid;
   logic [4:0]           fwd_addr;
   logic [XLEN-1:0]      fwd_value;
   logic                 load_pending;
   logic [4:0]           load_rd;
   logic [INSTRET_W-1:0] instret;

   modport master (
      output in_valid, in_rd_en, in_rd_addr, in_wb_sel, in_alu_result, in_pc,
             in_funct3, in_addr_lo, mem_rvalid, mem_rdata, flush,
      input  in_ready, rf_write_en, rf_write_addr, rf_write_value,
             fwd_valid, fwd_addr, fwd_value, load_pending, load_rd, instret
   );

   modport slave (
      input  in_valid, in_rd_en, in_rd_addr, in_wb_sel, in_alu_result, in_pc,
             in_funct3, in_addr_lo, mem_rvalid, mem_rdata, flush,
      output in_ready, rf_write_en, rf_write_addr, rf_write_value,
             fwd_valid, fwd_addr, fwd_value, load_pending, load_rd, instret
   );
endinterface

// File: rtl/wb_stage_load_extend.sv
// Load data alignment: selects the byte/half addressed by addr_lo and sign- or zero-extends it.
module load_extend
   import wb_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] value_o
);

   logic        [7:0]  byte_w;
   logic        [15:0] half_w;
   logic signed [7:0]  sbyte_w;
   logic signed [15:0] shalf_w;

   always_comb begin
      byte_w = rdata_i[7:0];
      case (addr_lo_i)
         2'd1:    byte_w = rdata_i[15:8];
         2'd2:    byte_w = rdata_i[23:16];
         2'd3:    byte_w = rdata_i[31:24];
         default: byte_w = rdata_i[7:0];
      endcase
      half_w  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      sbyte_w = signed'(byte_w);
      shalf_w = signed'(half_w);

      // Unknown codes fall back to the full word, same as LW
      case (funct3_i)
         F3_LB:   value_o = XLEN'(sbyte_w);
         F3_LBU:  value_o = XLEN'(byte_w);
         F3_LH:   value_o = XLEN'(shalf_w);
         F3_LHU:  value_o = XLEN'(half_w);
         default: value_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU/PC+4 results directly, waits in WAIT_LOAD for load data,
// and is the only driver of the register-file write port, its bypass copy and instret.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int INSTRET_W = 64
) (
   input  logic   clk,
   input  logic   reset_n,
   wb_stage_if.slave bus
);

   state_t                state_q, state_d;
   logic                  wen_q, wen_d;
   logic [4:0]            waddr_q, waddr_d;
   logic [XLEN-1:0]       wval_q, wval_d;
   logic [4:0]            ld_rd_q, ld_rd_d;
   logic [2:0]            ld_f3_q;
   logic [1:0]            ld_lo_q;
   logic [INSTRET_W-1:0]  instret_q, instret_d;
   logic [XLEN-1:0]       ld_value_w;
   logic                  accept_w;

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .funct3_i  (ld_f3_q),
      .addr_lo_i (ld_lo_q),
      .rdata_i   (bus.mem_rdata),
      .value_o   (ld_value_w)
   );

   assign accept_w = (state_q == IDLE) && bus.in_valid && !bus.flush;

   always_comb begin
      state_d   = state_q;
      wen_d     = 1'b0;
      waddr_d   = waddr_q;
      wval_d    = wval_q;
      ld_rd_d   = ld_rd_q;
      instret_d = instret_q;

      case (state_q)
         IDLE: begin
            if (accept_w) begin
               if (bus.in_wb_sel == WB_SEL_MEM) begin
                  // ld_rd_q doubles as the deferred write enable: nonzero means a real write
                  ld_rd_d = (bus.in_rd_en && bus.in_rd_addr != 5'd0) ? bus.in_rd_addr : 5'd0;
                  state_d = WAIT_LOAD;
               end else begin
                  instret_d = instret_q + 1'b1;
                  wen_d     = bus.in_rd_en && (bus.in_rd_addr != 5'd0);
                  if (wen_d) begin
                     waddr_d = bus.in_rd_addr;
                     wval_d  = (bus.in_wb_sel == WB_SEL_PC4) ? bus.in_pc + XLEN'(4)
                                                            : bus.in_alu_result;
                  end
               end
            end
         end
         WAIT_LOAD: begin
            if (bus.flush) begin
               ld_rd_d = 5'd0;
               state_d = IDLE;
            end else if (bus.mem_rvalid) begin
               instret_d = instret_q + 1'b1;
               wen_d     = (ld_rd_q != 5'd0);
               if (wen_d) begin
                  waddr_d = ld_rd_q;
                  wval_d  = ld_value_w;
               end
               ld_rd_d = 5'd0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wval_q    <= '0;
         ld_rd_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         wval_q    <= wval_d;
         ld_rd_q   <= ld_rd_d;
         instret_q <= instret_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept_w && bus.in_wb_sel == WB_SEL_MEM) begin
         ld_f3_q <= bus.in_funct3;
         ld_lo_q <= bus.in_addr_lo;
      end
   end

   assign bus.in_ready       = (state_q == IDLE);
   assign bus.rf_write_en    = wen_q;
   assign bus.rf_write_addr  = waddr_q;
   assign bus.rf_write_value = wval_q;
   assign bus.fwd_valid      = wen_q;
   assign bus.fwd_addr       = waddr_q;
   assign bus.fwd_value      = wval_q;
   assign bus.load_pending   = (state_q == WAIT_LOAD);
   assign bus.load_rd        = ld_rd_q;
   assign bus.instret        = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table-driven ALU/PC4 retires and load extensions, plus
// hand-written flush, reset-mid-load and instret wrap sequences.
module tb_wb_stage;
   import wb_stage_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   wb_stage_if #(.XLEN(32), .INSTRET_W(64)) bus ();

   wb_stage #(.XLEN(32), .INSTRET_W(64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] exp_ir;

   typedef struct {
      logic        rd_en;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [31:0] pc;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wval;
   } alu_vec_t;

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic        rd_en;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic        wen;
      logic [4:0]  ld_rd;
      logic [4:0]  waddr;
      logic [31:0] wval;
   } ld_vec_t;

   alu_vec_t av[6];
   ld_vec_t  lv[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] v);
      chk({tag, ".rf_write_en"},    64'(bus.rf_write_en),    64'(en));
      chk({tag, ".rf_write_addr"},  64'(bus.rf_write_addr),  64'(a));
      chk({tag, ".rf_write_value"}, 64'(bus.rf_write_value), 64'(v));
      chk({tag, ".fwd_valid"},      64'(bus.fwd_valid),      64'(en));
      chk({tag, ".fwd_addr"},       64'(bus.fwd_addr),       64'(a));
      chk({tag, ".fwd_value"},      64'(bus.fwd_value),      64'(v));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      bus.in_valid      = 1'b0;
      bus.in_rd_en      = 1'b0;
      bus.in_rd_addr    = '0;
      bus.in_wb_sel     = WB_SEL_ALU;
      bus.in_alu_result = '0;
      bus.in_pc         = '0;
      bus.in_funct3     = '0;
      bus.in_addr_lo    = '0;
      bus.mem_rvalid    = 1'b0;
      bus.mem_rdata     = '0;
      bus.flush         = 1'b0;
   endtask

   task automatic drive_op(input logic rd_en, input logic [4:0] rd, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] pc,
                           input logic [2:0] f3, input logic [1:0] lo);
      bus.in_valid      = 1'b1;
      bus.in_rd_en      = rd_en;
      bus.in_rd_addr    = rd;
      bus.in_wb_sel     = sel;
      bus.in_alu_result = alu;
      bus.in_pc         = pc;
      bus.in_funct3     = f3;
      bus.in_addr_lo    = lo;
   endtask

   initial begin
      av[0] = '{1'b1, 5'd5,  2'd0, 32'h1234_5678, 32'h0,         1'b1, 5'd5,  32'h1234_5678};
      av[1] = '{1'b1, 5'd0,  2'd0, 32'h0000_DEAD, 32'h0,         1'b0, 5'd5,  32'h1234_5678};
      av[2] = '{1'b1, 5'd1,  2'd2, 32'h1111_1111, 32'hFFFF_FFFC, 1'b1, 5'd1,  32'h0000_0000};
      av[3] = '{1'b0, 5'd9,  2'd0, 32'h0000_AAAA, 32'h0,         1'b0, 5'd1,  32'h0000_0000};
      av[4] = '{1'b1, 5'd31, 2'd3, 32'hCAFE_BABE, 32'h0000_0040, 1'b1, 5'd31, 32'hCAFE_BABE};
      av[5] = '{1'b1, 5'd2,  2'd2, 32'h0,         32'h0000_0100, 1'b1, 5'd2,  32'h0000_0104};

      lv[0] = '{F3_LB,  2'd3, 1'b1, 5'd10, 32'h80FF_7F01, 1'b1, 5'd10, 5'd10, 32'hFFFF_FF80};
      lv[1] = '{F3_LBU, 2'd1, 1'b1, 5'd11, 32'h80FF_7F01, 1'b1, 5'd11, 5'd11, 32'h0000_007F};
      lv[2] = '{F3_LH,  2'd2, 1'b1, 5'd12, 32'h80FF_7F01, 1'b1, 5'd12, 5'd12, 32'hFFFF_80FF};
      lv[3] = '{F3_LHU, 2'd0, 1'b1, 5'd13, 32'h80FF_7F01, 1'b1, 5'd13, 5'd13, 32'h0000_7F01};
      lv[4] = '{F3_LW,  2'd0, 1'b1, 5'd14, 32'h80FF_7F01, 1'b1, 5'd14, 5'd14, 32'h80FF_7F01};
      lv[5] = '{3'b011, 2'd1, 1'b1, 5'd15, 32'h1357_9BDF, 1'b1, 5'd15, 5'd15, 32'h1357_9BDF};
      lv[6] = '{F3_LB,  2'd0, 1'b1, 5'd0,  32'h0000_00FF, 1'b0, 5'd0,  5'd15, 32'h1357_9BDF};

      clear_inputs();
      reset_n = 1'b0;
      #12;
      chk_wr("reset", 1'b0, 5'd0, 32'h0);
      chk("reset.in_ready",     64'(bus.in_ready),     64'd1);
      chk("reset.load_pending", 64'(bus.load_pending), 64'd0);
      chk("reset.load_rd",      64'(bus.load_rd),      64'd0);
      chk("reset.instret",      bus.instret,           64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      exp_ir = 64'd0;

      // Back-to-back ALU / PC4 retires
      for (int i = 0; i < 6; i++) begin
         drive_op(av[i].rd_en, av[i].rd, av[i].sel, av[i].alu, av[i].pc, 3'b0, 2'b0);
         tick();
         exp_ir = exp_ir + 64'd1;
         chk_wr($sformatf("alu%0d", i), av[i].wen, av[i].waddr, av[i].wval);
         chk($sformatf("alu%0d.instret", i), bus.instret, exp_ir);
         chk($sformatf("alu%0d.in_ready", i), 64'(bus.in_ready), 64'd1);
      end
      clear_inputs();
      tick();
      chk_wr("idle", 1'b0, 5'd2, 32'h0000_0104);
      chk("idle.instret", bus.instret, exp_ir);

      // mem_rvalid while IDLE is ignored
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hFFFF_FFFF;
      tick();
      clear_inputs();
      chk_wr("rvalid_idle", 1'b0, 5'd2, 32'h0000_0104);
      chk("rvalid_idle.instret", bus.instret, exp_ir);

      // Loads, three cycles from acceptance to rvalid
      for (int i = 0; i < 7; i++) begin
         drive_op(lv[i].rd_en, lv[i].rd, WB_SEL_MEM, 32'hBAD0_BAD0, 32'h0, lv[i].f3, lv[i].lo);
         tick();
         clear_inputs();
         bus.mem_rdata = 32'hDEAD_BEEF;
         for (int w = 0; w < 3; w++) begin
            chk($sformatf("ld%0d.w%0d.rf_write_en", i, w), 64'(bus.rf_write_en), 64'd0);
            chk($sformatf("ld%0d.w%0d.in_ready", i, w), 64'(bus.in_ready), 64'd0);
            chk($sformatf("ld%0d.w%0d.load_pending", i, w), 64'(bus.load_pending), 64'd1);
            chk($sformatf("ld%0d.w%0d.load_rd", i, w), 64'(bus.load_rd), 64'(lv[i].ld_rd));
            if (w < 2) tick();
         end
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = lv[i].rdata;
         tick();
         clear_inputs();
         exp_ir = exp_ir + 64'd1;
         chk_wr($sformatf("ld%0d", i), lv[i].wen, lv[i].waddr, lv[i].wval);
         chk($sformatf("ld%0d.instret", i), bus.instret, exp_ir);
         chk($sformatf("ld%0d.in_ready", i), 64'(bus.in_ready), 64'd1);
         chk($sformatf("ld%0d.load_pending", i), 64'(bus.load_pending), 64'd0);
         chk($sformatf("ld%0d.load_rd", i), 64'(bus.load_rd), 64'd0);
         tick();
         chk($sformatf("ld%0d.strobe_once", i), 64'(bus.rf_write_en), 64'd0);
      end

      // Flush and mem_rvalid together while a load is pending
      drive_op(1'b1, 5'd7, WB_SEL_MEM, 32'h0, 32'h0, F3_LW, 2'd0);
      tick();
      clear_inputs();
      chk("flushld.load_rd", 64'(bus.load_rd), 64'd7);
      bus.flush      = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h7777_7777;
      tick();
      clear_inputs();
      chk_wr("flushld", 1'b0, 5'd15, 32'h1357_9BDF);
      chk("flushld.in_ready",     64'(bus.in_ready),     64'd1);
      chk("flushld.load_pending", 64'(bus.load_pending), 64'd0);
      chk("flushld.load_rd",      64'(bus.load_rd),      64'd0);
      chk("flushld.instret",      bus.instret,           exp_ir);

      // Flush in IDLE blocks acceptance
      drive_op(1'b1, 5'd3, WB_SEL_ALU, 32'h3333_3333, 32'h0, 3'b0, 2'b0);
      bus.flush = 1'b1;
      tick();
      clear_inputs();
      chk_wr("flushidle", 1'b0, 5'd15, 32'h1357_9BDF);
      chk("flushidle.instret", bus.instret, exp_ir);

      // A registered write survives a flush raised in its own cycle
      drive_op(1'b1, 5'd4, WB_SEL_ALU, 32'h4444_4444, 32'h0, 3'b0, 2'b0);
      tick();
      clear_inputs();
      exp_ir = exp_ir + 64'd1;
      bus.flush = 1'b1;
      #1;
      chk_wr("flushwr", 1'b1, 5'd4, 32'h4444_4444);
      tick();
      clear_inputs();
      chk("flushwr.after", 64'(bus.rf_write_en), 64'd0);
      chk("flushwr.instret", bus.instret, exp_ir);

      // Reset while a load is pending
      drive_op(1'b1, 5'd8, WB_SEL_MEM, 32'h0, 32'h0, F3_LW, 2'd0);
      tick();
      clear_inputs();
      chk("rstld.load_pending", 64'(bus.load_pending), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_wr("rstld.async", 1'b0, 5'd0, 32'h0);
      chk("rstld.async.load_rd", 64'(bus.load_rd), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h8888_8888;
      tick();
      clear_inputs();
      chk_wr("rstld", 1'b0, 5'd0, 32'h0);
      chk("rstld.in_ready",     64'(bus.in_ready),     64'd1);
      chk("rstld.load_pending", 64'(bus.load_pending), 64'd0);
      chk("rstld.load_rd",      64'(bus.load_rd),      64'd0);
      chk("rstld.instret",      bus.instret,           64'd0);

      // instret wrap from all-ones
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      chk("wrap.preload", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
      drive_op(1'b1, 5'd6, WB_SEL_ALU, 32'h0000_0055, 32'h0, 3'b0, 2'b0);
      tick();
      clear_inputs();
      chk_wr("wrap", 1'b1, 5'd6, 32'h0000_0055);
      chk("wrap.instret", bus.instret, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
